// File: rtl/encap_uart_tx_streamer.sv
`timescale 1ns/1ps
// encap_uart_tx_streamer: reads the C0, C1 and K result words and sends them LSB-byte first as 8N1 UART frames.
// Define UART_TX_CHECKSUM_EN to append one XOR-of-all-data-bytes frame after the last K byte.
module encap_uart_tx_streamer #(
    parameter int DBITS    = 8,
    parameter int SB_TICK  = 16,
    parameter int C0_WORDS = 24,
    parameter int C1_WORDS = 8,
    parameter int K_WORDS  = 8,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    output logic              rd_en,
    output logic [1:0]        rd_sel,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              o_uart_tx,
    output logic              busy,
    output logic              done
);

    localparam int TW = $clog2(SB_TICK);
    localparam int BW = (DBITS > 1) ? $clog2(DBITS) : 1;
    localparam logic [TW-1:0]     TICK_LAST = TW'(SB_TICK - 1);
    localparam logic [BW-1:0]     BIT_LAST  = BW'(DBITS - 1);
    localparam logic [ADDR_W-1:0] C0_LAST   = ADDR_W'(C0_WORDS - 1);
    localparam logic [ADDR_W-1:0] C1_LAST   = ADDR_W'(C1_WORDS - 1);
    localparam logic [ADDR_W-1:0] K_LAST    = ADDR_W'(K_WORDS - 1);

    localparam logic [2:0] W_IDLE  = 3'd0;
    localparam logic [2:0] W_FETCH = 3'd1;
    localparam logic [2:0] W_WAIT  = 3'd2;
    localparam logic [2:0] W_SEND  = 3'd3;
    localparam logic [2:0] W_FIN   = 3'd4;
`ifdef UART_TX_CHECKSUM_EN
    localparam logic [2:0] W_CSUM  = 3'd5;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [2:0]        w_state_q, w_state_d;
    logic              rd_en_q, rd_en_d;
    logic [1:0]        rd_sel_q, rd_sel_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [23:0]       word_q, word_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [1:0]        s_state_q, s_state_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DBITS-1:0]  sh_q, sh_d;
    logic              tx_q, tx_d;
`ifdef UART_TX_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              load_s;
    logic [7:0]        load_byte_s;
    logic              byte_done_s;
    logic [ADDR_W-1:0] sec_last_s;

    // Last stop tick of the current frame; lets the next byte start with no idle gap.
    assign byte_done_s = (s_state_q == S_STOP) && tick && (tcnt_q == TICK_LAST);

    // Last word address of the section currently being read.
    always_comb begin
        case (rd_sel_q)
            2'd0:    sec_last_s = C0_LAST;
            2'd1:    sec_last_s = C1_LAST;
            default: sec_last_s = K_LAST;
        endcase
    end

    // Word sequencer: fetch, latch, hand bytes to the serializer, walk sections.
    always_comb begin
        w_state_d   = w_state_q;
        rd_en_d     = 1'b0;
        rd_sel_d    = rd_sel_q;
        rd_addr_d   = rd_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        word_d      = word_q;
        byte_idx_d  = byte_idx_q;
        load_s      = 1'b0;
        load_byte_s = 8'h00;
`ifdef UART_TX_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (w_state_q)
            W_IDLE: begin
                if (start) begin
                    busy_d    = 1'b1;
                    rd_sel_d  = 2'd0;
                    rd_addr_d = '0;
                    rd_en_d   = 1'b1;
                    w_state_d = W_FETCH;
`ifdef UART_TX_CHECKSUM_EN
                    csum_d    = 8'h00;
`endif
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_FETCH: w_state_d = W_WAIT;
            W_WAIT: begin
                // rd_data is valid only in this cycle; byte 0 goes straight to the serializer.
                word_d      = rd_data[31:8];
                byte_idx_d  = 2'd0;
                load_s      = 1'b1;
                load_byte_s = rd_data[7:0];
`ifdef UART_TX_CHECKSUM_EN
                csum_d      = csum_q ^ rd_data[7:0];
`endif
                w_state_d   = W_SEND;
            end
            W_SEND: begin
                if (!byte_done_s) begin
                    w_state_d = W_SEND;
                end else if (byte_idx_q != 2'd3) begin
                    byte_idx_d  = byte_idx_q + 2'd1;
                    load_s      = 1'b1;
                    load_byte_s = word_q[7:0];
                    word_d      = {8'h00, word_q[23:8]};
`ifdef UART_TX_CHECKSUM_EN
                    csum_d      = csum_q ^ word_q[7:0];
`endif
                end else if (rd_addr_q < sec_last_s) begin
                    rd_addr_d = rd_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    rd_en_d   = 1'b1;
                    w_state_d = W_FETCH;
                end else if (rd_sel_q < 2'd2) begin
                    rd_sel_d  = rd_sel_q + 2'd1;
                    rd_addr_d = '0;
                    rd_en_d   = 1'b1;
                    w_state_d = W_FETCH;
                end else begin
`ifdef UART_TX_CHECKSUM_EN
                    load_s      = 1'b1;
                    load_byte_s = csum_q;
                    w_state_d   = W_CSUM;
`else
                    done_d      = 1'b1;
                    w_state_d   = W_FIN;
`endif
                end
            end
`ifdef UART_TX_CHECKSUM_EN
            W_CSUM: begin
                if (byte_done_s) begin
                    done_d    = 1'b1;
                    w_state_d = W_FIN;
                end else begin
                    w_state_d = W_CSUM;
                end
            end
`endif
            W_FIN: begin
                busy_d    = 1'b0;
                w_state_d = W_IDLE;
            end
            default: begin
                busy_d    = 1'b0;
                w_state_d = W_IDLE;
            end
        endcase
    end

    // Serializer: start, DBITS data bits LSB first, stop; all timing counted in ticks.
    always_comb begin
        s_state_d = s_state_q;
        tcnt_d    = tcnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        tx_d      = tx_q;
        case (s_state_q)
            S_IDLE: begin
                if (load_s) begin
                    s_state_d = S_START;
                    tcnt_d    = '0;
                    sh_d      = DBITS'(load_byte_s);
                    tx_d      = 1'b0;
                end else begin
                    tx_d = 1'b1;
                end
            end
            S_START: begin
                if (tick && (tcnt_q == TICK_LAST)) begin
                    s_state_d = S_DATA;
                    tcnt_d    = '0;
                    bit_d     = '0;
                    tx_d      = sh_q[0];
                end else if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            S_DATA: begin
                if (tick && (tcnt_q == TICK_LAST)) begin
                    tcnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        s_state_d = S_STOP;
                        tx_d      = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                    end
                end else if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            S_STOP: begin
                if (byte_done_s && load_s) begin
                    s_state_d = S_START;
                    tcnt_d    = '0;
                    sh_d      = DBITS'(load_byte_s);
                    tx_d      = 1'b0;
                end else if (byte_done_s) begin
                    s_state_d = S_IDLE;
                    tcnt_d    = '0;
                    tx_d      = 1'b1;
                end else if (tick) begin
                    tcnt_d = tcnt_q + 1'b1;
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            default: begin
                s_state_d = S_IDLE;
                tx_d      = 1'b1;
            end
        endcase
    end

    // State registers; reset forces the line high at once, truncating any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q  <= W_IDLE;
            rd_en_q    <= 1'b0;
            rd_sel_q   <= 2'd0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            word_q     <= 24'h000000;
            byte_idx_q <= 2'd0;
            s_state_q  <= S_IDLE;
            tcnt_q     <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            tx_q       <= 1'b1;
`ifdef UART_TX_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            w_state_q  <= w_state_d;
            rd_en_q    <= rd_en_d;
            rd_sel_q   <= rd_sel_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            s_state_q  <= s_state_d;
            tcnt_q     <= tcnt_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            tx_q       <= tx_d;
`ifdef UART_TX_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_sel    = rd_sel_q;
    assign rd_addr   = rd_addr_q;
    assign o_uart_tx = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/encap_uart_tx_streamer.md
Name: encap_uart_tx_streamer

Overview:
Return-path UART transmitter for the encapsulation harness. After the encapsulation core asserts done, it reads the result memories word by word and serializes them as 8N1 UART frames on o_uart_tx. Sections go out in the order ciphertext C0, then C1, then session key K. It shares the 16x-oversampled tick from the existing baud_rate_generator with the UART receiver.

Parameters:
DBITS, 8, data bits per UART frame.
SB_TICK, 16, ticks per bit period; also the stop-bit length in ticks.
C0_WORDS, 24, 32-bit words in C0, = ceil(l/32); must be >= 1.
C1_WORDS, 8, 32-bit words in C1; must be >= 1.
K_WORDS, 8, 32-bit words in K; must be >= 1.
ADDR_W, 5, width of rd_addr; must satisfy 2^ADDR_W >= max(C0_WORDS, C1_WORDS, K_WORDS).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
tick  in  1  one-cycle oversample strobe from baud_rate_generator.
start  in  1  pulse; begins a stream when idle (tie to the encapsulation core's done).
rd_en  out  1  memory read strobe.
rd_sel  out  2  read source: 0 = C0, 1 = C1, 2 = K; 3 is never driven.
rd_addr  out  ADDR_W  word address within the selected section.
rd_data  in  32  read word, valid exactly 1 cycle after rd_en.
o_uart_tx  out  1  serial line; idle level is high.
busy  out  1  high from accepted start until done.
done  out  1  one-cycle pulse after the last stop bit completes.

Behaviour:
Reset (asynchronous, rst = 0) takes effect immediately and clears all state:
- o_uart_tx = 1; busy = 0; done = 0; rd_en = 0; rd_sel = 0; rd_addr = 0.
- Both FSMs return to IDLE.
- Reset mid-frame truncates the frame; the line returns high immediately.

Word FSM: IDLE -> FETCH -> WAIT -> SEND -> (FETCH | NEXTSEC | FIN).
- IDLE: when start = 1, set busy = 1, rd_sel = 0, rd_addr = 0, and go to FETCH. start while busy is ignored.
- FETCH: drive rd_en = 1 for exactly one cycle; go to WAIT.
- WAIT: latch rd_data into the 32-bit shift register and set byte_idx = 0; go to SEND.
- SEND: hand bytes to the serial FSM, least-significant byte first (bits [7:0], then [15:8], and so on). After byte 3's stop bit finishes:
  - if rd_addr < section_words-1: increment rd_addr and go to FETCH;
  - else if rd_sel < 2: increment rd_sel, clear rd_addr, and go to FETCH (NEXTSEC);
  - else go to FIN.
- FIN: pulse done for one cycle, clear busy, return to IDLE.

Serial FSM: S_IDLE -> S_START -> S_DATA -> S_STOP.
- Tick counter is 4 bits wide (clog2(SB_TICK)) and advances only on tick = 1.
- S_START: o_uart_tx = 0 for SB_TICK ticks.
- S_DATA: DBITS bits, LSB first, each held for SB_TICK ticks.
- S_STOP: o_uart_tx = 1 for SB_TICK ticks.
- Frame boundaries are counted only in ticks; tick = 0 freezes the FSM and holds the line.
- Consecutive bytes are back-to-back: the next start bit begins on the tick after the previous stop bit ends.

Totals:
- Byte count = 4*(C0_WORDS + C1_WORDS + K_WORDS) = 160 at defaults.
- Memory reads per stream: exactly C0_WORDS + C1_WORDS + K_WORDS.
- start arriving on the same cycle as done is ignored; the FSM must first be in IDLE.

Optional Feature:
Macro UART_TX_CHECKSUM_EN.
- Defined: a running 8-bit XOR of every transmitted data byte is kept, cleared when start is accepted. After the last K byte, one extra frame carrying the XOR value is sent before FIN. Total is 161 frames at defaults.
- Undefined: no checksum register and no extra frame; FIN follows the last K byte directly.

Test Plan:
1. tick tied to 1; C0[0] = 0x44332211; pulse start -> first frames on the line are 0x11, 0x22, 0x33, 0x44; each bit is 16 cycles wide; the first start bit falls within 3 cycles of start.
2. Full stream at defaults -> 160 frames decoded by a bench-side Receiver; rd_en pulse count = 40; rd_sel order 0, 1, 2; done pulses once; busy is high throughout.
3. tick every 4th cycle -> bit width = 64 cycles; o_uart_tx stays stable between ticks.
4. Second start pulse mid-stream -> ignored; frame count remains 160; no extra reads.
5. rst driven low in the middle of C1 word 3, data bit 5 -> o_uart_tx = 1 in the same cycle; busy = 0; a new start then resends from C0[0].
6. UART_TX_CHECKSUM_EN defined, all words = 0x01020304 -> 161 frames; final byte is 0x00 (XOR of 0x04, 0x03, 0x02, 0x01 over an even number of words = 0x04 ^ 0x03 ^ 0x02 ^ 0x01 repeated 40 times).
